fpu_issue_stage: RTL and testbench

Sequencing stage that wraps the combinational fpu in the CPU execute path. It accepts one FP operation per valid/ready handshake and registers the operands and SELECT onto the fpu inputs. It holds them stable for an operation-dependent number of cycles, then captures RESULT and presents it downstream with a valid/ready handshake. This lets the slow combinational paths (divide, fused multiply-add) be given multicycle timing without stalling the whole pipeline on a fixed worst case.

---
 rtl/fpu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_fpu_issue_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_stage.sv
// Issue/retire wrapper around the combinational fpu: registers one operation,
// holds it for an opcode-dependent number of cycles, then hands the result downstream.
module fpu_issue_stage #(
    parameter int unsigned LAT_SIMPLE = 1,
    parameter int unsigned LAT_ADD    = 2,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 8,
    parameter int unsigned LAT_FMA    = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_DATA1,
    input  logic [31:0] IN_DATA2,
    input  logic [31:0] IN_DATA3,
    input  logic [4:0]  IN_SELECT,
    input  logic [4:0]  IN_RD,
    output logic [31:0] FPU_DATA1,
    output logic [31:0] FPU_DATA2,
    output logic [31:0] FPU_DATA3,
    output logic [4:0]  FPU_SELECT,
    input  logic [31:0] FPU_RESULT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_RESULT,
    output logic [4:0]  OUT_RD
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fpu_data1_q, fpu_data1_d;
    logic [31:0]      fpu_data2_q, fpu_data2_d;
    logic [31:0]      fpu_data3_q, fpu_data3_d;
    logic [4:0]       fpu_select_q, fpu_select_d;
    logic [4:0]       rd_q, rd_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             in_ready;
    logic             accept;

    // Counter preload is latency minus one so a zero count means "capture this edge".
    function automatic logic [CNT_W-1:0] lat_load(input logic [4:0] sel);
        int unsigned lat;
        case (sel)
            5'b00001, 5'b00010:                         lat = LAT_ADD;
            5'b00011:                                   lat = LAT_MUL;
            5'b00100, 5'b01101:                         lat = LAT_DIV;
            5'b01110, 5'b01111, 5'b10000, 5'b10001:     lat = LAT_FMA;
            default:                                    lat = LAT_SIMPLE;
        endcase
        return CNT_W'(lat - 1);
    endfunction

    always_comb begin
        in_ready = !RESET && !FLUSH &&
                   ((state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY));
        accept   = IN_VALID && in_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        fpu_data1_d  = fpu_data1_q;
        fpu_data2_d  = fpu_data2_q;
        fpu_data3_d  = fpu_data3_q;
        fpu_select_d = fpu_select_q;
        rd_d         = rd_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;

        case (state_q)
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_result_d = FPU_RESULT;
                    out_rd_d     = rd_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accept in DONE overrides the return to IDLE set just above.
        if (accept) begin
            fpu_data1_d  = IN_DATA1;
            fpu_data2_d  = IN_DATA2;
            fpu_data3_d  = IN_DATA3;
            fpu_select_d = IN_SELECT;
            rd_d         = IN_RD;
            cnt_d        = lat_load(IN_SELECT);
            state_d      = S_BUSY;
        end

        if (FLUSH) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fpu_data1_q  <= '0;
            fpu_data2_q  <= '0;
            fpu_data3_q  <= '0;
            fpu_select_q <= '0;
            rd_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fpu_data1_q  <= fpu_data1_d;
            fpu_data2_q  <= fpu_data2_d;
            fpu_data3_q  <= fpu_data3_d;
            fpu_select_q <= fpu_select_d;
            rd_q         <= rd_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
        end
    end

    assign IN_READY   = in_ready;
    assign FPU_DATA1  = fpu_data1_q;
    assign FPU_DATA2  = fpu_data2_q;
    assign FPU_DATA3  = fpu_data3_q;
    assign FPU_SELECT = fpu_select_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_RESULT = out_result_q;
    assign OUT_RD     = out_rd_q;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Bench for fpu_issue_stage: a stand-in fpu, a vector table, directed corner
// sequences, and a queue scoreboard tracking every accepted op to its delivery.
module tb_fpu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data1, in_data2, in_data3;
    logic [4:0]  in_select, in_rd, fpu_select, out_rd;
    logic [31:0] fpu_data1, fpu_data2, fpu_data3, fpu_result, out_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue_stage #(
        .LAT_SIMPLE(1), .LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(8), .LAT_FMA(4), .CNT_W(4)
    ) dut (
        .CLK(clk), .RESET(reset), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA1(in_data1), .IN_DATA2(in_data2), .IN_DATA3(in_data3),
        .IN_SELECT(in_select), .IN_RD(in_rd),
        .FPU_DATA1(fpu_data1), .FPU_DATA2(fpu_data2), .FPU_DATA3(fpu_data3),
        .FPU_SELECT(fpu_select), .FPU_RESULT(fpu_result),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_RESULT(out_result), .OUT_RD(out_rd)
    );

    // Stand-in fpu: exact answers for the documented vectors, FSGNJN on code 00111,
    // zero for unused codes, and an operand hash for everything else.
    function automatic logic [31:0] fpu_model(input logic [4:0] s, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        if (s == 5'b00001 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (s == 5'b00011 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (s == 5'b00100 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (s == 5'b01110 && a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000)
            return 32'h40E00000;
        if (s == 5'b00111) return {~b[31], a[30:0]};
        if (s >= 5'b10101) return 32'h0;
        return a ^ {b[15:0], b[31:16]} ^ (c + 32'h9E3779B9) ^ {27'd0, s};
    endfunction

    function automatic int lat_of(input logic [4:0] s);
        case (s)
            5'b00001, 5'b00010:                     return 2;
            5'b00011:                               return 3;
            5'b00100, 5'b01101:                     return 8;
            5'b01110, 5'b01111, 5'b10000, 5'b10001: return 4;
            default:                                return 1;
        endcase
    endfunction

    assign fpu_result = fpu_model(fpu_select, fpu_data1, fpu_data2, fpu_data3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } sb_t;
    sb_t sb[$];
    bit  seen = 0;

    // Sampled mid-cycle: decides what the coming rising edge will do.
    always @(negedge clk) begin
        sb_t e;
        if (reset || flush) begin
            sb.delete();
            seen = 0;
        end else begin
            if (out_valid && !seen) begin
                seen = 1;
                check("sb_depth", sb.size(), 1);
                if (sb.size() > 0) check("sb_latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_result", out_result, e.res);
                check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                seen = 0;
            end
            if (in_valid && in_ready) begin
                e.res = fpu_model(in_select, in_data1, in_data2, in_data3);
                e.rd  = in_rd;
                e.acc = cyc + 1;
                e.lat = lat_of(in_select);
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns with the op accepted at the last edge; acc is that edge's index.
    task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, output int acc);
        in_valid = 1'b1; in_select = s; in_data1 = a; in_data2 = b; in_data3 = c; in_rd = rd;
        acc = -100;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                step();
                acc = cyc;
                in_valid = 1'b0;
                return;
            end
            step();
            #1;
        end
        in_valid = 1'b0;
        check("issue_timeout", {31'd0, in_ready}, 1);
    endtask

    task automatic wait_valid(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                got = 1;
                return;
            end
            step();
        end
        check("valid_timeout", {31'd0, out_valid}, 1);
    endtask

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] d1, d2, d3;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, first_v;
        bit got, busy_ok, hold_ok, quiet_ok;

        vecs[0]  = '{5'b00001, 32'h3FC00000, 32'h40100000, 32'h0,        5'd5,  32'h40700000, 2};
        vecs[1]  = '{5'b00010, 32'h12345678, 32'h9ABCDEF0, 32'h0,        5'd7,  32'h0,        2};
        vecs[2]  = '{5'b00011, 32'h40000000, 32'h40400000, 32'h0,        5'd1,  32'h40C00000, 3};
        vecs[3]  = '{5'b00100, 32'h40C00000, 32'h40000000, 32'h0,        5'd2,  32'h40400000, 8};
        vecs[4]  = '{5'b01101, 32'h41100000, 32'h0,        32'h0,        5'd3,  32'h0,        8};
        vecs[5]  = '{5'b01110, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd4,  32'h40E00000, 4};
        vecs[6]  = '{5'b10001, 32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 5'd6,  32'h0,        4};
        vecs[7]  = '{5'b00111, 32'h40000000, 32'h40400000, 32'h0,        5'd9,  32'hC0000000, 1};
        vecs[8]  = '{5'b10010, 32'h11111111, 32'h22222222, 32'h33333333, 5'd10, 32'h0,        1};
        vecs[9]  = '{5'b10101, 32'h44444444, 32'h55555555, 32'h66666666, 5'd31, 32'h0,        1};
        vecs[10] = '{5'b11111, 32'h77777777, 32'h88888888, 32'h99999999, 5'd30, 32'h0,        1};
        vecs[11] = '{5'b00000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0,        5'd11, 32'h0,        1};
        vecs[12] = '{5'b01100, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0,        5'd12, 32'h0,        1};
        foreach (vecs[i]) begin
            if (i inside {1, 4, 6, 8, 11, 12})
                vecs[i].res = fpu_model(vecs[i].sel, vecs[i].d1, vecs[i].d2, vecs[i].d3);
        end

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data1 = '0; in_data2 = '0; in_data3 = '0; in_select = 5'b00001; in_rd = 5'd3;
        step(); step();
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", {27'd0, out_rd}, 0);
        check("rst_fpu_select", {27'd0, fpu_select}, 0);
        check("rst_fpu_data1", fpu_data1, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 1);

        // Vector table, downstream always ready.
        foreach (vecs[i]) begin
            issue(vecs[i].sel, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rd, acc);
            busy_ok = 1; hold_ok = 1; got = 0;
            for (int k = 0; k < 40; k++) begin
                if (out_valid) begin
                    got = 1;
                    break;
                end
                if (in_ready) busy_ok = 0;
                if (fpu_data3 !== vecs[i].d3 || fpu_select !== vecs[i].sel ||
                    fpu_data1 !== vecs[i].d1) hold_ok = 0;
                step();
            end
            check("vec_got_valid", {31'd0, got}, 1);
            check("vec_latency", cyc - acc, vecs[i].lat);
            check("vec_result", out_result, vecs[i].res);
            check("vec_rd", {27'd0, out_rd}, {27'd0, vecs[i].rd});
            check("vec_busy_not_ready", {31'd0, busy_ok}, 1);
            check("vec_fpu_hold", {31'd0, hold_ok}, 1);
            step();
            check("vec_valid_drop", {31'd0, out_valid}, 0);
        end

        // FDIV with three cycles of backpressure.
        out_ready = 1'b0;
        issue(5'b00100, 32'h40C00000, 32'h40000000, 32'h0, 5'd8, acc);
        wait_valid(got);
        check("bp_latency", cyc - acc, 8);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid_held", {31'd0, out_valid}, 1);
            check("bp_result_held", out_result, 32'h40400000);
            check("bp_rd_held", {27'd0, out_rd}, 5'd8);
        end
        out_ready = 1'b1;
        step();
        check("bp_valid_drop", {31'd0, out_valid}, 0);

        // Back-to-back: second op accepted in the DONE handshake cycle.
        issue(5'b00011, 32'h40000000, 32'h40400000, 32'h0, 5'd13, acc);
        wait_valid(got);
        first_v = cyc;
        check("b2b_first_result", out_result, 32'h40C00000);
        check("b2b_ready_in_done", {31'd0, in_ready}, 1);
        issue(5'b00111, 32'h40000000, 32'h40400000, 32'h0, 5'd14, acc2);
        check("b2b_accept_edge", acc2, first_v + 1);
        check("b2b_gap", {31'd0, out_valid}, 0);
        step();
        check("b2b_second_valid", {31'd0, out_valid}, 1);
        check("b2b_second_result", out_result, 32'hC0000000);
        check("b2b_second_rd", {27'd0, out_rd}, 5'd14);
        step();

        // FLUSH in the third cycle of an FDIV, with a new op offered during the flush.
        issue(5'b00100, 32'h40C00000, 32'h40000000, 32'h0, 5'd15, acc);
        step(); step();
        flush = 1'b1;
        in_valid = 1'b1; in_select = 5'b00001; in_data1 = 32'h3FC00000; in_data2 = 32'h40100000;
        in_rd = 5'd16;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_ready_after", {31'd0, in_ready}, 1);
        quiet_ok = 1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) quiet_ok = 0;
            step();
        end
        check("flush_no_valid", {31'd0, quiet_ok}, 1);
        issue(5'b00001, 32'h3FC00000, 32'h40100000, 32'h0, 5'd17, acc);
        wait_valid(got);
        check("flush_fadd_latency", cyc - acc, 2);
        check("flush_fadd_result", out_result, 32'h40700000);
        check("flush_fadd_rd", {27'd0, out_rd}, 5'd17);
        step();

        // RESET while a result waits in DONE.
        out_ready = 1'b0;
        issue(5'b01110, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd18, acc);
        wait_valid(got);
        check("rd_done_result", out_result, 32'h40E00000);
        reset = 1'b1;
        #1;
        check("rd_in_ready_rst", {31'd0, in_ready}, 0);
        step();
        check("rd_out_valid", {31'd0, out_valid}, 0);
        check("rd_out_result", out_result, 0);
        check("rd_out_rd", {27'd0, out_rd}, 0);
        check("rd_fpu_select", {27'd0, fpu_select}, 0);
        check("rd_fpu_data3", fpu_data3, 0);
        check("rd_in_ready_held", {31'd0, in_ready}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rd_in_ready_release", {31'd0, in_ready}, 1);
        step(); step();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
